// File: rtl/batt_bar_pkg.sv
// Shared mode encoding, count-width derivation and thermometer encoder for the battery LED bar.
package batt_bar_pkg;

  localparam int MAX_LEDS = 64;

  typedef enum logic [1:0] {
    MODE_NORMAL,
    MODE_LOW,
    MODE_CHARGE
  } bar_mode_t;

  function automatic int count_width(input int n_leds);
    return $clog2(n_leds + 1);
  endfunction

  // Callers size-cast the result down to their own bar width.
  function automatic logic [MAX_LEDS-1:0] thermometer(input int unsigned count);
    logic [MAX_LEDS-1:0] t;
    for (int i = 0; i < MAX_LEDS; i++) begin
      t[i] = (unsigned'(i) < count);
    end
    return t;
  endfunction

endpackage

// File: rtl/batt_tick_gen.sv
// Display-tick prescaler: counts 0..TICK_DIV-1 and flags the last count for exactly one cycle.
module batt_tick_gen #(
  parameter int TICK_DIV = 1000000
) (
  input  logic clk,
  input  logic rst,
  output logic tick_o
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == CW'(TICK_DIV - 1));

  always_comb begin
    cnt_d = tick_o ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/battery_bar_driver.sv
// Battery LED bar: ramped thermometer display, low-level blink, fill animation when BATT_CHARGE_ANIM_EN is defined.
// led_bar/low_warn are registered one cycle behind disp_count; no backpressure, a new level is taken on any valid cycle.
module battery_bar_driver
  import batt_bar_pkg::*;
#(
  parameter int N_LEDS      = 8,
  parameter int LEVEL_W     = 4,
  parameter int TICK_DIV    = 1000000,
  parameter int LOW_THRESH  = 1,
  parameter int BLINK_TICKS = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             level_valid,
  input  logic [LEVEL_W-1:0]               level,
  input  logic                             charging,
  output logic [N_LEDS-1:0]                led_bar,
  output logic [count_width(N_LEDS)-1:0]   disp_count,
  output logic                             low_warn
);

  localparam int DW = count_width(N_LEDS);
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  logic              tick;
  bar_mode_t         mode;
  logic              low;
  logic [31:0]       level_ext;
  logic [31:0]       low_count;
  logic [DW-1:0]     chg_count;
  logic [DW-1:0]     target_q, target_d;
  logic [DW-1:0]     disp_q, disp_d;
  logic [BW-1:0]     blink_cnt_q, blink_cnt_d;
  logic              phase_q, phase_d;
  logic [N_LEDS-1:0] led_q, led_d;
  logic              warn_q, warn_d;

  batt_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk   (clk),
    .rst   (rst),
    .tick_o(tick)
  );

  assign level_ext = 32'(level);
  assign low       = (32'(disp_q) <= 32'(LOW_THRESH));
  assign low_count = (disp_q == '0) ? 32'd1 : 32'(disp_q);

`ifdef BATT_CHARGE_ANIM_EN
  logic [DW-1:0] pos_q, pos_d;

  // pos_q sits at 0 outside CHARGE, so the max() makes the fill start from disp_count.
  assign chg_count = (pos_q > disp_q) ? pos_q : disp_q;

  always_comb begin
    pos_d = '0;
    if (mode == MODE_CHARGE) begin
      pos_d = chg_count;
      if (tick) pos_d = (32'(chg_count) >= 32'(N_LEDS)) ? disp_q : chg_count + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) pos_q <= '0;
    else     pos_q <= pos_d;
  end
`else
  assign chg_count = disp_q;
`endif

  always_comb begin
    mode = MODE_NORMAL;
    if (charging) mode = MODE_CHARGE;
    else if (low) mode = MODE_LOW;

    target_d = target_q;
    if (level_valid) begin
      target_d = (level_ext > 32'(N_LEDS)) ? DW'(N_LEDS) : DW'(level_ext);
    end

    // Uses target_q, so a level arriving on a tick cycle only steers later ticks.
    disp_d = disp_q;
    if (tick) begin
      if (disp_q < target_q)      disp_d = disp_q + 1'b1;
      else if (disp_q > target_q) disp_d = disp_q - 1'b1;
    end

    blink_cnt_d = '0;
    phase_d     = 1'b1;
    if (mode == MODE_LOW) begin
      blink_cnt_d = blink_cnt_q;
      phase_d     = phase_q;
      if (tick) begin
        if (blink_cnt_q == BW'(BLINK_TICKS - 1)) begin
          blink_cnt_d = '0;
          phase_d     = !phase_q;
        end else begin
          blink_cnt_d = blink_cnt_q + 1'b1;
        end
      end
    end

    case (mode)
      MODE_CHARGE: led_d = N_LEDS'(thermometer(32'(chg_count)));
      MODE_LOW:    led_d = phase_q ? N_LEDS'(thermometer(low_count)) : '0;
      default:     led_d = N_LEDS'(thermometer(32'(disp_q)));
    endcase

    warn_d = low && !charging;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      target_q    <= '0;
      disp_q      <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
      led_q       <= '0;
      warn_q      <= 1'b0;
    end else begin
      target_q    <= target_d;
      disp_q      <= disp_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      led_q       <= led_d;
      warn_q      <= warn_d;
    end
  end

  assign led_bar    = led_q;
  assign disp_count = disp_q;
  assign low_warn   = warn_q;

endmodule

// File: tb/tb_battery_bar_driver.sv
// Scoreboarded directed test of battery_bar_driver (N_LEDS=8, TICK_DIV=4, LOW_THRESH=1, BLINK_TICKS=2).
module tb_battery_bar_driver;

`ifdef BATT_CHARGE_ANIM_EN
  localparam bit ANIM = 1'b1;
`else
  localparam bit ANIM = 1'b0;
`endif

  localparam int R = 3;
  localparam logic [2:0] L = 3'b100;
  localparam logic [2:0] D = 3'b010;
  localparam logic [2:0] W = 3'b001;

  typedef struct {
    int         at;
    logic [2:0] mask;
    logic [7:0] led;
    logic [3:0] disp;
    logic       warn;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       level_valid = 1'b0;
  logic [3:0] level = 4'd0;
  logic       charging = 1'b0;
  logic [7:0] led_bar;
  logic [3:0] disp_count;
  logic       low_warn;

  int    cyc = 0;
  int    n_chk = 0;
  int    n_pass = 0;
  exp_t  exp_q[$];
  string name_q[$];

  battery_bar_driver #(
    .N_LEDS(8), .LEVEL_W(4), .TICK_DIV(4), .LOW_THRESH(1), .BLINK_TICKS(2)
  ) dut (
    .clk(clk), .rst(rst), .level_valid(level_valid), .level(level),
    .charging(charging), .led_bar(led_bar), .disp_count(disp_count), .low_warn(low_warn)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic ex(input int at, input logic [2:0] m, input logic [7:0] l,
                    input logic [3:0] d, input logic w, input string nm);
    exp_t e;
    e.at = at; e.mask = m; e.led = l; e.disp = d; e.warn = w;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic chk(input string nm, input string f, input logic [7:0] got, input logic [7:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s %s @cyc %0d: got %h want %h", nm, f, cyc, got, want);
  endtask

  // Monitor: pops every expectation due this cycle and compares sampled outputs.
  always @(negedge clk) begin : monitor
    exp_t  e;
    string nm;
    while (exp_q.size() > 0 && exp_q[0].at <= cyc) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      if (e.at != cyc) begin
        n_chk++;
        $display("FAIL %s late: due cycle %0d, now %0d", nm, e.at, cyc);
      end else begin
        if (e.mask[2]) chk(nm, "led_bar", led_bar, e.led);
        if (e.mask[1]) chk(nm, "disp_count", {4'd0, disp_count}, {4'd0, e.disp});
        if (e.mask[0]) chk(nm, "low_warn", {7'd0, low_warn}, {7'd0, e.warn});
      end
    end
  end

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Level is set to 0xF afterwards so an ignored non-valid level would be visible.
  task automatic pulse(input int at, input logic [3:0] lvl);
    wait_cyc(at);
    level = lvl;
    level_valid = 1'b1;
    wait_cyc(at + 1);
    level_valid = 1'b0;
    level = 4'hF;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    ex(R,      L|D|W, 8'h00, 4'd0, 1'b0, "reset_state");
    ex(R+1,    L|W,   8'h01, 4'd0, 1'b1, "warn_after_release");
    ex(R+8,    L,     8'h01, 4'd0, 1'b0, "blink_on_end");
    ex(R+9,    L,     8'h00, 4'd0, 1'b0, "blink_off_start");
    ex(R+16,   L,     8'h00, 4'd0, 1'b0, "blink_off_end");
    ex(R+17,   L,     8'h01, 4'd0, 1'b0, "blink_on_again");
    wait_cyc(R);
    rst = 1'b0;

    ex(R+23,   D,     8'h00, 4'd0, 1'b0, "ramp_before_tick");
    ex(R+24,   D,     8'h00, 4'd1, 1'b0, "ramp_first_step");
    ex(R+28,   D|W,   8'h00, 4'd2, 1'b1, "warn_lag");
    ex(R+29,   L|W,   8'h03, 4'd0, 1'b0, "normal_after_low");
    ex(R+39,   D,     8'h00, 4'd4, 1'b0, "ramp_at_4");
    ex(R+40,   L|D,   8'h0F, 4'd5, 1'b0, "ramp_reach_5");
    ex(R+41,   L|W,   8'h1F, 4'd0, 1'b0, "ramp_final_bar");
    pulse(R+20, 4'd5);

    ex(R+52,   D,     8'h00, 4'd7, 1'b0, "clamp_at_7");
    ex(R+56,   D,     8'h00, 4'd8, 1'b0, "clamp_reach_8");
    ex(R+57,   L,     8'hFF, 4'd0, 1'b0, "clamp_bar");
    ex(R+63,   L|D,   8'hFF, 4'd8, 1'b0, "clamp_hold");
    pulse(R+44, 4'd12);

    ex(R+76,   D,     8'h00, 4'd5, 1'b0, "down_to_5");
    ex(R+84,   D,     8'h00, 4'd5, 1'b0, "tick_with_valid_old_target");
    ex(R+85,   L,     8'h1F, 4'd0, 1'b0, "bar_at_5");
    ex(R+88,   D,     8'h00, 4'd4, 1'b0, "new_target_next_tick");
    ex(R+100,  D|W,   8'h00, 4'd1, 1'b0, "reach_1_warn_lag");
    ex(R+101,  L|D|W, 8'h01, 4'd1, 1'b1, "low_entry_on");
    ex(R+108,  L,     8'h01, 4'd0, 1'b0, "low_on_end");
    ex(R+109,  L,     8'h00, 4'd0, 1'b0, "low_blink_off");
    ex(R+116,  L,     8'h00, 4'd0, 1'b0, "low_off_end");
    ex(R+117,  L,     8'h01, 4'd0, 1'b0, "low_blink_on");
    pulse(R+64, 4'd5);
    pulse(R+83, 4'd1);

    ex(R+136,  D,     8'h00, 4'd5, 1'b0, "charge_setup_5");
    ex(R+137,  L|W,   8'h1F, 4'd0, 1'b0, "pre_charge_normal");
    ex(R+138,  L|W,   8'h1F, 4'd0, 1'b0, "charge_entry");
    ex(R+140,  L,     8'h1F, 4'd0, 1'b0, "charge_pos5_hold");
    ex(R+141,  L|W,   ANIM ? 8'h3F : 8'h1F, 4'd0, 1'b0, "anim_step6");
    ex(R+145,  L,     ANIM ? 8'h7F : 8'h1F, 4'd0, 1'b0, "anim_step7");
    ex(R+149,  L|W,   ANIM ? 8'hFF : 8'h1F, 4'd0, 1'b0, "anim_step8");
    ex(R+152,  L,     ANIM ? 8'hFF : 8'h1F, 4'd0, 1'b0, "anim_hold_full");
    ex(R+153,  L,     8'h1F, 4'd0, 1'b0, "anim_wrap");
    ex(R+158,  L,     ANIM ? 8'h3F : 8'h1F, 4'd0, 1'b0, "charge_last");
    ex(R+159,  L|W,   8'h1F, 4'd0, 1'b0, "charge_release");
    pulse(R+120, 4'd5);
    wait_cyc(R+137);
    charging = 1'b1;
    wait_cyc(R+158);
    charging = 1'b0;

    ex(R+172,  D,     8'h00, 4'd2, 1'b0, "mid_down_2");
    ex(R+176,  D,     8'h00, 4'd3, 1'b0, "mid_up_3");
    ex(R+178,  D,     8'h00, 4'd3, 1'b0, "mid_ramp_3");
    ex(R+179,  L|D|W, 8'h00, 4'd0, 1'b0, "reset_mid_ramp");
    ex(R+180,  L|D|W, 8'h01, 4'd0, 1'b1, "post_reset_low");
    ex(R+182,  D,     8'h00, 4'd0, 1'b0, "restart_before_tick");
    ex(R+183,  D,     8'h00, 4'd1, 1'b0, "restart_step1");
    ex(R+187,  D,     8'h00, 4'd2, 1'b0, "restart_step2");
    ex(R+188,  L|W,   8'h03, 4'd0, 1'b0, "restart_bar");
    pulse(R+160, 4'd2);
    pulse(R+172, 4'd8);
    wait_cyc(R+178);
    rst = 1'b1;
    wait_cyc(R+179);
    rst = 1'b0;
    pulse(R+180, 4'd2);

    wait_cyc(R+195);
    n_chk++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
